warp_xwb_arbiter: RTL and testbench

//  Shares the two warp_xrf write ports between the two fixed-latency integer lanes (xarith/xlogic/xshift/xmultl)
//  and the single long-latency result stream (xdiv/xmulth). Fixed lanes have absolute priority, since they cannot stall.

---
 rtl/warp_xwb_arbiter_pkg.sv | 16 +
 rtl/warp_xwb_fifo.sv | 49 ++++
 rtl/warp_xwb_arbiter.sv | 111 +++++++++++
 tb/tb_warp_xwb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_xwb_arbiter_pkg.sv
// Shared types and constants for the warp_xrf write-back arbiter.
package warp_xwb_arbiter_pkg;

    localparam logic [4:0] XWB_RD_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } xwb_ent_t;

    // The credit counter must be able to hold LNG_DEPTH itself.
    function automatic int xwb_cred_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/warp_xwb_fifo.sv
// Long-result buffer: DEPTH entries, wrap-around pointers plus occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module warp_xwb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 69
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign o_head  = mem_q[rptr_q];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= i_wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/warp_xwb_arbiter.sv
// Shares the two warp_xrf write ports between fixed lanes A/B and buffered long results.
// Optional macro WARP_XWB_BYPASS_EN lets a long result skip an empty FIFO.
module warp_xwb_arbiter
    import warp_xwb_arbiter_pkg::*;
#(
    parameter int LNG_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_rd,
    input  logic [63:0] i_a_data,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_rd,
    input  logic [63:0] i_b_data,
    input  logic        i_lng_issue,
    input  logic        i_lng_valid,
    input  logic [4:0]  i_lng_rd,
    input  logic [63:0] i_lng_data,
    output logic        o_lng_credit,
    output logic        o_rd1_wen,
    output logic [4:0]  o_rd1_addr,
    output logic [63:0] o_rd1_wdata,
    output logic        o_rd2_wen,
    output logic [4:0]  o_rd2_addr,
    output logic [63:0] o_rd2_wdata,
    output logic        o_lng_retire,
    output logic [4:0]  o_lng_retire_rd
);
    localparam int CW = xwb_cred_w(LNG_DEPTH);

    xwb_ent_t        lng_in, fifo_head, cand;
    logic            fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic            a_ok, b_ok, a_wr, cand_v, cand_zero, place, byp, to_rd1, to_rd2;
    logic            issue_ok;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign lng_in = '{rd: i_lng_rd, data: i_lng_data};

    warp_xwb_fifo #(.DEPTH(LNG_DEPTH), .W($bits(xwb_ent_t))) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_wdata (lng_in),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    // Lane A loses to B on a shared destination: B is younger, so its value is the architectural one.
    assign a_ok = i_a_valid && (i_a_rd != XWB_RD_ZERO);
    assign b_ok = i_b_valid && (i_b_rd != XWB_RD_ZERO);
    assign a_wr = a_ok && !(b_ok && (i_a_rd == i_b_rd));

`ifdef WARP_XWB_BYPASS_EN
    assign cand_v = !fifo_empty || i_lng_valid;
    assign cand   = fifo_empty ? lng_in : fifo_head;
`else
    assign cand_v = !fifo_empty;
    assign cand   = fifo_head;
`endif

    // An x0 long result retires without needing a port.
    assign cand_zero = (cand.rd == XWB_RD_ZERO);
    assign place     = cand_v && (cand_zero || !a_wr || !b_ok);
    assign to_rd1    = place && !cand_zero && !a_wr;
    assign to_rd2    = place && !cand_zero && a_wr;
    assign byp       = place && fifo_empty;
    assign fifo_pop  = place && !fifo_empty;
    assign fifo_push = i_lng_valid && !byp;

    assign issue_ok = i_lng_issue && (cnt_q != '0);
    assign cnt_d    = cnt_q + {{(CW-1){1'b0}}, place} - {{(CW-1){1'b0}}, issue_ok};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q           <= CW'(LNG_DEPTH);
            o_lng_credit    <= 1'b1;
            o_rd1_wen       <= 1'b0;
            o_rd1_addr      <= '0;
            o_rd1_wdata     <= '0;
            o_rd2_wen       <= 1'b0;
            o_rd2_addr      <= '0;
            o_rd2_wdata     <= '0;
            o_lng_retire    <= 1'b0;
            o_lng_retire_rd <= '0;
        end else begin
            cnt_q           <= cnt_d;
            o_lng_credit    <= (cnt_d != '0);
            o_rd1_wen       <= a_wr || to_rd1;
            o_rd1_addr      <= a_wr ? i_a_rd   : (to_rd1 ? cand.rd   : '0);
            o_rd1_wdata     <= a_wr ? i_a_data : (to_rd1 ? cand.data : '0);
            o_rd2_wen       <= b_ok || to_rd2;
            o_rd2_addr      <= b_ok ? i_b_rd   : (to_rd2 ? cand.rd   : '0);
            o_rd2_wdata     <= b_ok ? i_b_data : (to_rd2 ? cand.data : '0);
            o_lng_retire    <= place;
            o_lng_retire_rd <= place ? cand.rd : '0;
        end
    end

    a_no_issue_without_credit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_lng_issue && (cnt_q == '0)));
    a_no_fifo_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(fifo_push && fifo_full && !fifo_pop));
    a_head_rd_not_lane_rd: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(cand_v && !cand_zero && ((a_ok && cand.rd == i_a_rd) || (b_ok && cand.rd == i_b_rd))));
    a_ports_distinct: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_rd1_wen && o_rd2_wen && (o_rd1_addr == o_rd2_addr)));

endmodule

// File: tb/tb_warp_xwb_arbiter.sv
// Scoreboard bench for warp_xwb_arbiter: expected port activity is queued as stimulus is driven.
module tb_warp_xwb_arbiter;

    typedef struct packed {
        logic av; logic [4:0] ard; logic [63:0] ad;
        logic bv; logic [4:0] brd; logic [63:0] bd;
        logic lv; logic [4:0] lrd; logic [63:0] ld;
        logic iss;
    } stim_t;

    typedef struct packed {
        logic w1; logic [4:0] a1; logic [63:0] d1;
        logic w2; logic [4:0] a2; logic [63:0] d2;
        logic ret; logic [4:0] rrd;
        logic cred;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        a_valid = 0, b_valid = 0, lng_issue = 0, lng_valid = 0;
    logic [4:0]  a_rd = 0, b_rd = 0, lng_rd = 0;
    logic [63:0] a_data = 0, b_data = 0, lng_data = 0;
    logic        lng_credit, rd1_wen, rd2_wen, lng_retire;
    logic [4:0]  rd1_addr, rd2_addr, lng_retire_rd;
    logic [63:0] rd1_wdata, rd2_wdata;

    int   n_vec = 0, n_bad = 0;
    exp_t sb[$];

    warp_xwb_arbiter #(.LNG_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data),
        .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data),
        .i_lng_issue(lng_issue), .i_lng_valid(lng_valid), .i_lng_rd(lng_rd), .i_lng_data(lng_data),
        .o_lng_credit(lng_credit),
        .o_rd1_wen(rd1_wen), .o_rd1_addr(rd1_addr), .o_rd1_wdata(rd1_wdata),
        .o_rd2_wen(rd2_wen), .o_rd2_addr(rd2_addr), .o_rd2_wdata(rd2_wdata),
        .o_lng_retire(lng_retire), .o_lng_retire_rd(lng_retire_rd)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                                input logic bv, input logic [4:0] brd, input logic [63:0] bd,
                                input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                                input logic iss);
        return '{av, ard, ad, bv, brd, bd, lv, lrd, ld, iss};
    endfunction

    function automatic exp_t E(input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                               input logic w2, input logic [4:0] a2, input logic [63:0] d2,
                               input logic ret, input logic [4:0] rrd, input logic cred);
        return '{w1, a1, d1, w2, a2, d2, ret, rrd, cred};
    endfunction

    // Address/data are don't-care while the matching strobe is low.
    function automatic exp_t observe();
        exp_t o;
        o = '{rd1_wen, rd1_wen ? rd1_addr : 5'd0, rd1_wen ? rd1_wdata : 64'd0,
              rd2_wen, rd2_wen ? rd2_addr : 5'd0, rd2_wen ? rd2_wdata : 64'd0,
              lng_retire, lng_retire ? lng_retire_rd : 5'd0, lng_credit};
        return o;
    endfunction

    task automatic apply(input stim_t s);
        a_valid = s.av;   a_rd = s.ard;   a_data = s.ad;
        b_valid = s.bv;   b_rd = s.brd;   b_data = s.bd;
        lng_valid = s.lv; lng_rd = s.lrd; lng_data = s.ld;
        lng_issue = s.iss;
    endtask

    task automatic do_reset();
        apply('0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    localparam exp_t IDLE1 = '{cred: 1'b1, default: '0};
    localparam exp_t IDLE0 = '{default: '0};

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  o, e;
        do_reset();
        apply(S(1, 5, 64'h11, 1, 7, 64'h22, 0, 0, 0, 1));
        sb.push_back(E(1, 5, 64'h11, 1, 7, 64'h22, 0, 0, 1));
        @(posedge clk); #1;
        apply(S(1, 5, 64'h15, 1, 7, 64'h27, 1, 6, 64'h66, 0));
        sb.push_back(E(1, 5, 64'h15, 1, 7, 64'h27, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin @(posedge clk); #1; end
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL reset_pre[%0d] got=%h want=%h", i, o, e); end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            o = observe(); n_vec++;
            if (o !== IDLE1) begin n_bad++; $display("FAIL reset_hold[%0d] got=%h want=%h", i, o, IDLE1); end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(IDLE1);
        for (int i = 0; i < 3; i++) begin
            st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(IDLE1);
        end
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(IDLE0);
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(IDLE0);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL reset_post[%0d] got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_lanes();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  o, e;
        do_reset();
        st.push_back(S(1, 5, 64'h11, 1, 7, 64'h22, 0, 0, 0, 0)); ex.push_back(E(1, 5, 64'h11, 1, 7, 64'h22, 0, 0, 1));
        st.push_back(S(1, 9, 64'hAA, 1, 9, 64'hBB, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 1, 9, 64'hBB, 0, 0, 1));
        st.push_back(S(1, 0, 64'h33, 0, 0, 0, 0, 0, 0, 0));      ex.push_back(IDLE1);
        st.push_back(S(1, 4, 64'h44, 1, 0, 64'h55, 0, 0, 0, 0)); ex.push_back(E(1, 4, 64'h44, 0, 0, 0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 1, 31, 64'hFFFF_0000_1234_5678, 0, 0, 0, 0));
        ex.push_back(E(0, 0, 0, 1, 31, 64'hFFFF_0000_1234_5678, 0, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));           ex.push_back(IDLE1);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL lanes[%0d] got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_long_queued();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  o, e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            ex.push_back(i == 3 ? IDLE0 : IDLE1);
        end
        st.push_back(S(1, 1, 64'h101, 1, 2, 64'h102, 1, 3, 64'hD1, 0));
        ex.push_back(E(1, 1, 64'h101, 1, 2, 64'h102, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            st.push_back(S(1, 1, 64'h201 + i, 1, 2, 64'h202 + i, 0, 0, 0, 0));
            ex.push_back(E(1, 1, 64'h201 + i, 1, 2, 64'h202 + i, 0, 0, 0));
        end
        st.push_back(S(0, 0, 0, 1, 2, 64'h302, 0, 0, 0, 0));
        ex.push_back(E(1, 3, 64'hD1, 1, 2, 64'h302, 1, 3, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(IDLE1);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL long_queued[%0d] got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_fill_drain();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  o, e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            ex.push_back(i == 3 ? IDLE0 : IDLE1);
        end
        for (int i = 0; i < 4; i++) begin
            st.push_back(S(1, 1, 64'h100 + i, 1, 2, 64'h200 + i, 1, 5'(10 + i), 64'hC0 + i, 0));
            ex.push_back(E(1, 1, 64'h100 + i, 1, 2, 64'h200 + i, 0, 0, 0));
        end
        // Drain through rd2 while A keeps rd1; from the 2nd drain on, an issue offsets each pop.
        for (int i = 0; i < 4; i++) begin
            st.push_back(S(1, 1, 64'h110 + i, 0, 0, 0, 0, 0, 0, i != 0));
            ex.push_back(E(1, 1, 64'h110 + i, 1, 5'(10 + i), 64'hC0 + i, 1, 5'(10 + i), 1));
        end
        st.push_back(S(1, 1, 64'h120, 0, 0, 0, 0, 0, 0, 1));
        ex.push_back(E(1, 1, 64'h120, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL fill_drain[%0d] got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_long_rd0();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  o, e;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(IDLE1);
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(IDLE1);
        st.push_back(S(1, 1, 64'hA1, 1, 2, 64'hB1, 1, 4, 64'h44, 0)); ex.push_back(E(1, 1, 64'hA1, 1, 2, 64'hB1, 0, 0, 1));
        st.push_back(S(1, 1, 64'hA2, 1, 2, 64'hB2, 1, 0, 64'hEE, 0)); ex.push_back(E(1, 1, 64'hA2, 1, 2, 64'hB2, 0, 0, 1));
        st.push_back(S(1, 1, 64'hA3, 1, 2, 64'hB3, 0, 0, 0, 0));      ex.push_back(E(1, 1, 64'hA3, 1, 2, 64'hB3, 0, 0, 1));
        st.push_back(S(0, 0, 0, 1, 2, 64'hB4, 0, 0, 0, 0));           ex.push_back(E(1, 4, 64'h44, 1, 2, 64'hB4, 1, 4, 1));
        st.push_back(S(1, 1, 64'hA5, 1, 2, 64'hB5, 0, 0, 0, 0));      ex.push_back(E(1, 1, 64'hA5, 1, 2, 64'hB5, 1, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));                ex.push_back(IDLE1);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL long_rd0[%0d] got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_latency();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  o, e;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));         ex.push_back(IDLE1);
`ifdef WARP_XWB_BYPASS_EN
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 12, 64'h5A, 0));   ex.push_back(E(1, 12, 64'h5A, 0, 0, 0, 1, 12, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(IDLE1);
`else
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 12, 64'h5A, 0));   ex.push_back(IDLE1);
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 12, 64'h5A, 0, 0, 0, 1, 12, 1));
`endif
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(IDLE1);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            o = observe(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL latency[%0d] got=%h want=%h", i, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_long_queued();
        test_fill_drain();
        test_long_rd0();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
